// File: rtl/stream_sink_if.sv
// Byte stream carrying valid/ready/last handshake between a source (master) and a sink (slave).
interface stream_sink_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stream_sink.sv
// Stream sink: circular FIFO of {last,data} beats drained through a registered pop port.
// Define STREAM_SINK_DROP_EN to always accept and discard beats offered while full (sticky overflow).
module stream_sink #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  stream_sink_if.slave      s,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_valid_o,
  output logic              dout_last_o,
  output logic [ADDR_W:0]   buff_count_o,
  output logic [ADDR_W:0]   frame_count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   frames_q, frames_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_last_q, dout_last_d;
  logic              dout_valid_q, dout_valid_d;

  logic              full;
  logic              empty;
  logic              accept;
  logic              rd_en;
  logic [DATA_W:0]   rd_entry;
  logic              rd_last;

  // Status decodes come from registered count only, so tready never depends on tvalid or pop.
  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign accept   = s.tvalid && !full;
  assign rd_en    = pop_i && !empty;
  assign rd_entry = mem_q[rd_ptr_q];
  assign rd_last  = rd_entry[DATA_W];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    frames_d     = frames_q;
    dout_d       = dout_q;
    dout_last_d  = dout_last_q;
    dout_valid_d = 1'b0;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (rd_en) begin
      rd_ptr_d     = rd_ptr_q + PTR_ONE;
      dout_d       = rd_entry[DATA_W-1:0];
      dout_last_d  = rd_last;
      dout_valid_d = 1'b1;
    end

    case ({accept, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case ({accept && s.tlast, rd_en && rd_last})
      2'b10:   frames_d = frames_q + CNT_ONE;
      2'b01:   frames_d = frames_q - CNT_ONE;
      default: frames_d = frames_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frames_q     <= '0;
      dout_q       <= '0;
      dout_last_q  <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frames_q     <= frames_d;
      dout_q       <= dout_d;
      dout_last_q  <= dout_last_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Storage is left uninitialised by reset; only pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= {s.tlast, s.tdata};
    end
  end

`ifdef STREAM_SINK_DROP_EN
  logic overflow_q, overflow_d;

  assign overflow_d = overflow_q || (s.tvalid && full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign s.tready   = 1'b1;
  assign overflow_o = overflow_q;
`else
  assign s.tready   = !full;
  assign overflow_o = 1'b0;
`endif

  assign dout_o        = dout_q;
  assign dout_valid_o  = dout_valid_q;
  assign dout_last_o   = dout_last_q;
  assign buff_count_o  = count_q;
  assign frame_count_o = frames_q;
  assign empty_o       = empty;
  assign full_o        = full;

endmodule

// File: tb/tb_stream_sink.sv
// Directed scoreboard bench for stream_sink: expected beats queued at stimulus, popped by a dout monitor.
module tb_stream_sink;

  logic       clk;
  logic       rst_n;
  logic       pop;
  logic [7:0] dout;
  logic       doutValid;
  logic       doutLast;
  logic [4:0] buffCount;
  logic [4:0] frameCount;
  logic       empty;
  logic       full;
  logic       overflow;

  int         total;
  int         bad;
  logic [8:0] expQ [$];

  stream_sink_if #(.DATA_W(8)) sIf ();

  stream_sink #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s            (sIf.slave),
    .pop_i        (pop),
    .dout_o       (dout),
    .dout_valid_o (doutValid),
    .dout_last_o  (doutLast),
    .buff_count_o (buffCount),
    .frame_count_o(frameCount),
    .empty_o      (empty),
    .full_o       (full),
    .overflow_o   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; returns 1 time unit after the edge so registered outputs are settled.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic p);
    sIf.tvalid = v;
    sIf.tdata  = d;
    sIf.tlast  = l;
    pop        = p;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBeat(input logic [7:0] d, input logic l, input logic p);
    expQ.push_back({l, d});
    applyStimulus(1'b1, d, l, p);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "Count"}, 32'(buffCount), 0);
    checkOutput({tag, "Frames"}, 32'(frameCount), 0);
    checkOutput({tag, "Empty"}, 32'(empty), 1);
    checkOutput({tag, "Full"}, 32'(full), 0);
    checkOutput({tag, "Dout"}, 32'(dout), 0);
    checkOutput({tag, "DoutValid"}, 32'(doutValid), 0);
    checkOutput({tag, "DoutLast"}, 32'(doutLast), 0);
    checkOutput({tag, "Overflow"}, 32'(overflow), 0);
    checkOutput({tag, "Tready"}, 32'(sIf.tready), 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && doutValid) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedPop: got data 0x%0h last %0b, expected nothing", dout, doutLast);
      end else begin
        logic [8:0] e;
        e = expQ.pop_front();
        checkOutput("doutData", 32'(dout), 32'(e[7:0]));
        checkOutput("doutLast", 32'(doutLast), 32'(e[8]));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected done by 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    pop        = 1'b0;
    sIf.tvalid = 1'b0;
    sIf.tdata  = 8'h00;
    sIf.tlast  = 1'b0;
    #1;
    checkReset("init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] frame of three beats");
    sendBeat(8'h11, 1'b0, 1'b0);
    sendBeat(8'h22, 1'b0, 1'b0);
    sendBeat(8'h33, 1'b1, 1'b0);
    checkOutput("frameCount3", 32'(frameCount), 1);
    checkOutput("count3", 32'(buffCount), 3);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("frameCountDrained", 32'(frameCount), 0);
    checkOutput("emptyDrained", 32'(empty), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] fill to full with back-pressure");
    for (int i = 0; i < 16; i++) begin
      sendBeat(8'(8'h40 + i), (i == 7), 1'b0);
    end
    checkOutput("fullCount", 32'(buffCount), 16);
    checkOutput("fullFlag", 32'(full), 1);
    checkOutput("fullTready", 32'(sIf.tready), 0);
    expQ.push_back({1'b1, 8'h99});
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
    checkOutput("heldCount", 32'(buffCount), 16);
    checkOutput("overflowOff", 32'(overflow), 0);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b1);
    checkOutput("afterPopCount", 32'(buffCount), 15);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
    checkOutput("refillCount", 32'(buffCount), 16);
    checkOutput("refillFrames", 32'(frameCount), 2);
    repeat (16) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("fullDrainedEmpty", 32'(empty), 1);
    checkOutput("fullDrainedFrames", 32'(frameCount), 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] streaming with pop every cycle across pointer wrap");
    for (int i = 0; i < 40; i++) begin
      sendBeat(8'(8'hA0 + i), ((i % 10) == 9), 1'b1);
      checkOutput("wrapCount", 32'(buffCount), 1);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("wrapEmpty", 32'(empty), 1);
    checkOutput("wrapFrames", 32'(frameCount), 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] simultaneous accept and pop, then pop while empty");
    for (int i = 0; i < 5; i++) begin
      sendBeat(8'(8'h51 + i), 1'b0, 1'b0);
    end
    checkOutput("count5", 32'(buffCount), 5);
    sendBeat(8'h56, 1'b0, 1'b1);
    checkOutput("count5Hold", 32'(buffCount), 5);
    repeat (5) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("count5Drained", 32'(buffCount), 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("emptyPopValid", 32'(doutValid), 0);
    checkOutput("emptyPopDoutHold", 32'(dout), 32'h56);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

`ifdef STREAM_SINK_DROP_EN
    $display("[TB] drop while full");
    for (int i = 0; i < 16; i++) begin
      sendBeat(8'(8'h60 + i), (i == 15), 1'b0);
    end
    checkOutput("dropTready", 32'(sIf.tready), 1);
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    checkOutput("dropCount", 32'(buffCount), 16);
    checkOutput("dropFrames", 32'(frameCount), 1);
    checkOutput("dropOverflow", 32'(overflow), 1);
    repeat (16) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("dropOverflowSticky", 32'(overflow), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
`else
    checkOutput("noDropOverflow", 32'(overflow), 0);
`endif

    $display("[TB] asynchronous reset mid-frame");
    sendBeat(8'h71, 1'b0, 1'b0);
    sendBeat(8'h72, 1'b1, 1'b0);
    sendBeat(8'h73, 1'b0, 1'b1);
    checkOutput("preResetValid", 32'(doutValid), 1);
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkReset("midReset");
    sIf.tvalid = 1'b0;
    pop        = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("postResetCount", 32'(buffCount), 0);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("leftoverExpected", 32'(expQ.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
